// File: rtl/uart_tx_engine.sv
// uart_tx_engine: byte FIFO feeding an 8N1 UART serializer.
// Back-to-back bytes leave with no idle gap between stop and start.
module uart_tx_engine #(
   parameter int CLKS_PER_BIT = 1085,
   parameter int FIFO_DEPTH   = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    fifo_wr_data,
   input  logic                          fifo_wr_en,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic                          overflow_err
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int BW   = ($clog2(CLKS_PER_BIT) > 16) ?
                         $clog2(CLKS_PER_BIT) : 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            done_q, done_d;
   logic            wr_ok;
   logic            pop;
   logic            bit_end;

   assign fifo_full    = (count_q == CNTW'(FIFO_DEPTH));
   assign fifo_empty   = (count_q == '0);
   assign fifo_count   = count_q;
   assign uart_tx      = tx_q;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done      = done_q;
   assign overflow_err = ovf_q;

   assign wr_ok   = fifo_wr_en && !fifo_full;
   assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

   // FIFO storage; stale entries need no reset since pointers do
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= fifo_wr_data;
      end
   end

   // FIFO pointer, occupancy and sticky overflow update
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_ok && !pop) begin
         count_d = count_q + CNTW'(1);
      end else if (pop && !wr_ok) begin
         count_d = count_q - CNTW'(1);
      end
      if (fifo_wr_en && fifo_full) begin
         ovf_d = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: STOP chains straight into START when data waits
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (!fifo_empty) state_d = START;
         START: if (bit_end) state_d = DATA;
         DATA:  if (bit_end && idx_q == 3'd7) state_d = STOP;
         STOP:  if (bit_end) state_d = fifo_empty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: pop, baud counter, shifter and registered line level
   always_comb begin
      pop     = 1'b0;
      baud_d  = '0;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            pop = !fifo_empty;
         end
         START: begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
            idx_d  = 3'd0;
            tx_d   = 1'b0;
         end
         DATA: begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
            tx_d   = shift_q[0];
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
            done_d = bit_end;
            pop    = bit_end && !fifo_empty;
         end
         default: begin
            pop = 1'b0;
         end
      endcase
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
      end
   end

   // Datapath and FIFO bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         baud_q   <= '0;
         idx_q    <= 3'd0;
         shift_q  <= 8'h00;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         baud_q   <= baud_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
      end
   end

endmodule
